axi_rr_arbiter: RTL
===================

// Module: axi_rr_arbiter
// PURPOSE
//  N-master to 1-slave AXI4 arbiter for the NPC memory path; successor to the fixed 2-port IFU/LSU arbiter.
//  Read (AR/R) and write (AW/W/B) channels are arbitrated independently, so they run concurrently.
//  Supports INCR bursts (arlen/awlen) and round-robin fairness.
//  Sits between the IFU/LSU/future DMA ports and the io_master_* SoC interface.
// PARAMETERS
//  NUM_MASTERS  2   number of upstream masters, >=1
//  ADDR_W       32  address width
//  DATA_W       32  data width; wstrb width = DATA_W/8
//  ID_W         4   io_master_arid/awid width; must satisfy 2**ID_W >= NUM_MASTERS
// PORTS
//  clock                     in   1          system clock
//  reset                     in   1          asynchronous, active-high reset
//  m_arvalid/m_arready       in/out  N       per-master AR handshake
//  m_araddr/m_arlen/m_arsize in   N*ADDR_W/N*8/N*3  per-master AR payload, flattened, master i at slice i
//  m_rvalid/m_rready         out/in  N       per-master R handshake
//  m_rdata/m_rresp/m_rlast   out  DATA_W/2/1 R payload broadcast to all masters; only rvalid is per-master
//  m_awvalid/m_awready       in/out  N       per-master AW handshake
//  m_awaddr/m_awlen/m_awsize in   N*ADDR_W/N*8/N*3  per-master AW payload
//  m_wvalid/m_wready         in/out  N       per-master W handshake
//  m_wdata/m_wstrb/m_wlast   in   N*DATA_W/N*DATA_W/8/N  per-master W payload
//  m_bvalid/m_bready         out/in  N       per-master B handshake
//  m_bresp                   out  2          B response broadcast
//  io_master_*               mixed  AXI4     downstream AR/R/AW/W/B with identical widths/semantics to the NPC top
// BEHAVIOUR
//  Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
//   - R_IDLE: if any m_arvalid, register grant rg = first requester after rptr (mod N); go to R_ADDR.
//   - R_ADDR: io_master_arvalid = m_arvalid[rg]; payload muxed from slice rg.
//     m_arready[rg] = io_master_arready. On handshake go to R_DATA.
//   - R_DATA: m_rvalid[rg] = io_master_rvalid; io_master_rready = m_rready[rg].
//     On handshake with rlast: rptr <= rg, go to R_IDLE.
//  Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE; wptr/wg handled as rptr/rg.
//   - W_ADDR: AW handshake as for AR.
//   - W_DATA: io_master_wvalid = m_wvalid[wg], m_wready[wg] = io_master_wready. Exits on the wlast handshake.
//   - W_RESP: m_bvalid[wg] = io_master_bvalid, io_master_bready = m_bready[wg]. Exits on the handshake.
//   - W asserted before the AW handshake is held off: m_wready = 0 outside W_DATA.
//  Non-granted masters: all ready/valid outputs 0. Payload inputs from non-granted masters are ignored.
//  io_master_arid/awid = grant index, zero-extended to ID_W. arburst/awburst = 2'b01.
//  rid/bid are not checked. rresp/bresp are passed through unmodified, including SLVERR/DECERR.
//  Latency: 1 cycle from first arvalid/awvalid to downstream valid (registered grant). Back-to-back grants lose 1 idle cycle.
//  Burst length is not counted: completion follows rlast/wlast only.
//  Same master may hold the read grant and the write grant simultaneously.
//  Reset (async):
//   - both FSMs go to IDLE; rptr/wptr = N-1, so master 0 is served first.
//   - every valid/ready output drops to 0 immediately.
//   - an in-flight transaction is abandoned; the downstream slave is reset with the same signal.
//  NUM_MASTERS=1: pointer width is max(1, clog2(N)) and grant is always 0.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: rptr/wptr are removed; grant = lowest-index requester (master 0 highest priority).
//  ARB_FIXED_PRIO_EN undefined: round-robin as above.
//  Handshake and FSM behaviour are identical in both modes.
// TESTING
//  1 Reset asserted mid R_DATA (N=2)
//    -> all m_* valids/readys and io_master_arvalid/rready are 0 in the same cycle.
//    -> after release, simultaneous arvalid from m0 and m1 grants m0 first.
//  2 N=3, all three masters assert single-beat reads continuously
//    -> grant order 0,1,2,0; io_master_arid = 0,1,2,0.
//  3 m1 read, arlen=3, araddr=0x3000_0000; m0 arvalid raised during beat 2
//    -> 4 beats reach only m1, m_rvalid[0] stays 0; m0 is granted one cycle after the rlast handshake.
//  4 m0 read concurrent with m1 write (awaddr=0x8000_0000, wdata=0xDEADBEEF, wstrb=4'hF)
//    -> both complete overlapped; bresp=2'b00 is delivered only to m1.
//  5 m1 raises wvalid 2 cycles before awvalid
//    -> m_wready[1]=0 until after the AW handshake; exactly one W beat is forwarded.
//  6 ARB_FIXED_PRIO_EN defined, m0 and m2 requesting continuously
//    -> m0 wins every arbitration and m2 is never granted.

Source files
------------

// File: rtl/axi_rr_arbiter.sv
// ============================================================================
// Module  : axi_rr_arbiter
// Purpose : N-master to 1-slave AXI4 arbiter, independent read/write channels.
//           `define ARB_FIXED_PRIO_EN selects fixed priority (master 0 highest)
//           instead of round-robin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  // upstream read
  input  logic [NUM_MASTERS-1:0]          m_arvalid,
  output logic [NUM_MASTERS-1:0]          m_arready,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_araddr,
  input  logic [NUM_MASTERS*8-1:0]        m_arlen,
  input  logic [NUM_MASTERS*3-1:0]        m_arsize,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  input  logic [NUM_MASTERS-1:0]          m_rready,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [1:0]                      m_rresp,
  output logic                            m_rlast,
  // upstream write
  input  logic [NUM_MASTERS-1:0]          m_awvalid,
  output logic [NUM_MASTERS-1:0]          m_awready,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_awaddr,
  input  logic [NUM_MASTERS*8-1:0]        m_awlen,
  input  logic [NUM_MASTERS*3-1:0]        m_awsize,
  input  logic [NUM_MASTERS-1:0]          m_wvalid,
  output logic [NUM_MASTERS-1:0]          m_wready,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]          m_wlast,
  output logic [NUM_MASTERS-1:0]          m_bvalid,
  input  logic [NUM_MASTERS-1:0]          m_bready,
  output logic [1:0]                      m_bresp,
  // downstream
  input  logic                            io_master_arready,
  output logic                            io_master_arvalid,
  output logic [ADDR_W-1:0]               io_master_araddr,
  output logic [ID_W-1:0]                 io_master_arid,
  output logic [7:0]                      io_master_arlen,
  output logic [2:0]                      io_master_arsize,
  output logic [1:0]                      io_master_arburst,
  output logic                            io_master_rready,
  input  logic                            io_master_rvalid,
  input  logic [1:0]                      io_master_rresp,
  input  logic [DATA_W-1:0]               io_master_rdata,
  input  logic                            io_master_rlast,
  input  logic [ID_W-1:0]                 io_master_rid,
  input  logic                            io_master_awready,
  output logic                            io_master_awvalid,
  output logic [ADDR_W-1:0]               io_master_awaddr,
  output logic [ID_W-1:0]                 io_master_awid,
  output logic [7:0]                      io_master_awlen,
  output logic [2:0]                      io_master_awsize,
  output logic [1:0]                      io_master_awburst,
  input  logic                            io_master_wready,
  output logic                            io_master_wvalid,
  output logic [DATA_W-1:0]               io_master_wdata,
  output logic [DATA_W/8-1:0]             io_master_wstrb,
  output logic                            io_master_wlast,
  output logic                            io_master_bready,
  input  logic                            io_master_bvalid,
  input  logic [1:0]                      io_master_bresp,
  input  logic [ID_W-1:0]                 io_master_bid
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wstate_t;

  rstate_t         rstate_q, rstate_d;
  wstate_t         wstate_q, wstate_d;
  logic [PW-1:0]   rg_q, rg_d, wg_q, wg_d;
  logic [NUM_MASTERS-1:0] r_onehot, w_onehot;
  logic            r_sel_arvalid, r_sel_rready, w_sel_awvalid, w_sel_wvalid, w_sel_bready;
  logic [PW-1:0]   r_pick, w_pick;

  // rid/bid are never interpreted
  logic unused_ids;
  assign unused_ids = ^{io_master_rid, io_master_bid};

`ifdef ARB_FIXED_PRIO_EN
  function automatic logic [PW-1:0] pick(input logic [NUM_MASTERS-1:0] req);
    pick = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (req[i]) pick = PW'(i);
  endfunction

  assign r_pick = pick(m_arvalid);
  assign w_pick = pick(m_awvalid);
`else
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;

  // Scan descending distance so the closest requester after ptr wins last.
  function automatic logic [PW-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                         input logic [PW-1:0] ptr);
    int idx;
    pick = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_MASTERS;
      if (req[idx]) pick = PW'(idx);
    end
  endfunction

  assign r_pick = pick(m_arvalid, rptr_q);
  assign w_pick = pick(m_awvalid, wptr_q);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstate_q <= R_IDLE;
      wstate_q <= W_IDLE;
      rg_q     <= '0;
      wg_q     <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rptr_q   <= PW'(NUM_MASTERS - 1);
      wptr_q   <= PW'(NUM_MASTERS - 1);
`endif
    end else begin
      rstate_q <= rstate_d;
      wstate_q <= wstate_d;
      rg_q     <= rg_d;
      wg_q     <= wg_d;
`ifndef ARB_FIXED_PRIO_EN
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
`endif
    end
  end

  // Payload and per-master handshake muxes driven by the registered grants.
  always_comb begin
    r_onehot          = '0;
    w_onehot          = '0;
    r_sel_arvalid     = 1'b0;
    r_sel_rready      = 1'b0;
    w_sel_awvalid     = 1'b0;
    w_sel_wvalid      = 1'b0;
    w_sel_bready      = 1'b0;
    io_master_araddr  = '0;
    io_master_arlen   = '0;
    io_master_arsize  = '0;
    io_master_awaddr  = '0;
    io_master_awlen   = '0;
    io_master_awsize  = '0;
    io_master_wdata   = '0;
    io_master_wstrb   = '0;
    io_master_wlast   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (rg_q == PW'(i)) begin
        r_onehot[i]      = 1'b1;
        r_sel_arvalid    = m_arvalid[i];
        r_sel_rready     = m_rready[i];
        io_master_araddr = m_araddr[i*ADDR_W +: ADDR_W];
        io_master_arlen  = m_arlen[i*8 +: 8];
        io_master_arsize = m_arsize[i*3 +: 3];
      end
      if (wg_q == PW'(i)) begin
        w_onehot[i]      = 1'b1;
        w_sel_awvalid    = m_awvalid[i];
        w_sel_wvalid     = m_wvalid[i];
        w_sel_bready     = m_bready[i];
        io_master_awaddr = m_awaddr[i*ADDR_W +: ADDR_W];
        io_master_awlen  = m_awlen[i*8 +: 8];
        io_master_awsize = m_awsize[i*3 +: 3];
        io_master_wdata  = m_wdata[i*DATA_W +: DATA_W];
        io_master_wstrb  = m_wstrb[i*SW +: SW];
        io_master_wlast  = m_wlast[i];
      end
    end
  end

  assign io_master_arid    = ID_W'(rg_q);
  assign io_master_awid    = ID_W'(wg_q);
  assign io_master_arburst = 2'b01;
  assign io_master_awburst = 2'b01;
  assign m_rdata           = io_master_rdata;
  assign m_rresp           = io_master_rresp;
  assign m_rlast           = io_master_rlast;
  assign m_bresp           = io_master_bresp;

  always_comb begin
    rstate_d          = rstate_q;
    rg_d              = rg_q;
`ifndef ARB_FIXED_PRIO_EN
    rptr_d            = rptr_q;
`endif
    m_arready         = '0;
    m_rvalid          = '0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (|m_arvalid) begin
          rg_d     = r_pick;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        io_master_arvalid = r_sel_arvalid;
        m_arready         = r_onehot & {NUM_MASTERS{io_master_arready}};
        if (r_sel_arvalid && io_master_arready) rstate_d = R_DATA;
      end
      R_DATA: begin
        m_rvalid         = r_onehot & {NUM_MASTERS{io_master_rvalid}};
        io_master_rready = r_sel_rready;
        if (io_master_rvalid && r_sel_rready && io_master_rlast) begin
`ifndef ARB_FIXED_PRIO_EN
          rptr_d   = rg_q;
`endif
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d          = wstate_q;
    wg_d              = wg_q;
`ifndef ARB_FIXED_PRIO_EN
    wptr_d            = wptr_q;
`endif
    m_awready         = '0;
    m_wready          = '0;
    m_bvalid          = '0;
    io_master_awvalid = 1'b0;
    io_master_wvalid  = 1'b0;
    io_master_bready  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (|m_awvalid) begin
          wg_d     = w_pick;
          wstate_d = W_ADDR;
        end
      end
      W_ADDR: begin
        io_master_awvalid = w_sel_awvalid;
        m_awready         = w_onehot & {NUM_MASTERS{io_master_awready}};
        if (w_sel_awvalid && io_master_awready) wstate_d = W_DATA;
      end
      // W data is only accepted here, so early W beats wait for the AW handshake.
      W_DATA: begin
        io_master_wvalid = w_sel_wvalid;
        m_wready         = w_onehot & {NUM_MASTERS{io_master_wready}};
        if (w_sel_wvalid && io_master_wready && io_master_wlast) wstate_d = W_RESP;
      end
      W_RESP: begin
        m_bvalid         = w_onehot & {NUM_MASTERS{io_master_bvalid}};
        io_master_bready = w_sel_bready;
        if (io_master_bvalid && w_sel_bready) begin
`ifndef ARB_FIXED_PRIO_EN
          wptr_d   = wg_q;
`endif
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

endmodule

`default_nettype wire
